conv_mem: RTL and testbench

CONV_MEM -- requirements
Module: conv_mem

---
 rtl/conv_mem_pkg.sv | 13 +
 rtl/conv_mem_array.sv | 50 +++++
 rtl/conv_mem.sv | 134 +++++++++++++
 tb/tb_conv_mem.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mem_pkg.sv
// Shared constants and FSM state type for the conv_mem block.
package conv_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

endpackage

// File: rtl/conv_mem_array.sv
// Single-port synchronous RAM with a registered read port.
// Read data holds its value until the next read completes.
module conv_mem_array
  import conv_pkg::*;
#(
  parameter int unsigned AW = conv_pkg::ADDR_W,
  parameter int unsigned DW = conv_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned WORDS = 1 << AW;

  logic [DW-1:0] mem [WORDS];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // Storage write; words are never cleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Next read data: load on a read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  // Output register, cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/conv_mem.sv
// conv_mem: word memory shared by a datapath port (priority) and a host port.
// Optional feature macro: CONV_MEM_INIT_CLEAR_EN -- when defined, the block
// starts in INIT after reset and sweeps zeros through every word before
// entering SERVE; otherwise it serves from reset release.
module conv_mem
  import conv_pkg::*;
#(
  parameter int unsigned ADDR_W = conv_pkg::ADDR_W,
  parameter int unsigned DATA_W = conv_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_index,
  input  logic [DATA_W-1:0] mem_in,
  input  logic              mem_wr,
  input  logic              mem_rd,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_valid,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic              ready
);

  logic              serve;
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;

`ifdef CONV_MEM_INIT_CLEAR_EN
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              ready_q, ready_d;

  // Sweep counter advances once per INIT cycle; last word moves us to SERVE.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == '1) begin
        state_d = ST_SERVE;
      end
    end
    ready_d = (state_d == ST_SERVE);
  end

  // FSM state, sweep counter and registered ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ready_q <= ready_d;
    end
  end

  assign serve      = (state_q == ST_SERVE);
  // Gated with rst so clock edges during reset do not touch word 0.
  assign sweep_we   = (state_q == ST_INIT) && rst;
  assign sweep_addr = sweep_q;
  assign ready      = ready_q;
`else
  assign serve      = 1'b1;
  assign sweep_we   = 1'b0;
  assign sweep_addr = '0;
  assign ready      = 1'b1;
`endif

  logic              dp_req;
  logic              dp_re;
  logic              host_re;
  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic              mem_valid_q, mem_valid_d;
  logic              host_rvalid_q, host_rvalid_d;

  // Arbitration: datapath always wins; a write+read pair performs only the write.
  always_comb begin
    dp_req   = mem_rd | mem_wr;
    host_gnt = serve & host_req & ~dp_req;
    dp_re    = serve & mem_rd & ~mem_wr;
    host_re  = host_gnt & ~host_wr;
    arr_we   = sweep_we | (serve & mem_wr) | (host_gnt & host_wr);
    arr_re   = dp_re | host_re;
    if (sweep_we) begin
      arr_addr  = sweep_addr;
      arr_wdata = '0;
    end else if (host_gnt) begin
      arr_addr  = host_addr;
      arr_wdata = host_wdata;
    end else begin
      arr_addr  = mem_index;
      arr_wdata = mem_in;
    end
    mem_valid_d   = dp_re;
    host_rvalid_d = host_re;
  end

  // Valid pipeline aligned with the RAM output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_valid_q   <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      mem_valid_q   <= mem_valid_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign mem_valid   = mem_valid_q;
  assign host_rvalid = host_rvalid_q;

  conv_mem_array #(
    .AW(ADDR_W),
    .DW(DATA_W)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .re   (arr_re),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(mem_out)
  );

endmodule

// File: tb/tb_conv_mem.sv
// Directed testbench for conv_mem; follows CONV_MEM_INIT_CLEAR_EN when defined.
module tb_conv_mem;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] mem_index;
  logic [DW-1:0] mem_in;
  logic          mem_wr;
  logic          mem_rd;
  logic [DW-1:0] mem_out;
  logic          mem_valid;
  logic          host_req;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic          ready;

  int n_checks = 0;
  int n_fail   = 0;

  conv_mem #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_index  (mem_index),
    .mem_in     (mem_in),
    .mem_wr     (mem_wr),
    .mem_rd     (mem_rd),
    .mem_out    (mem_out),
    .mem_valid  (mem_valid),
    .host_req   (host_req),
    .host_wr    (host_wr),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .ready      (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_index = a;
    mem_in    = d;
    mem_wr    = 1'b1;
    step();
    mem_wr    = 1'b0;
  endtask

  task automatic dp_rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    mem_index = a;
    mem_rd    = 1'b1;
    step();
    mem_rd    = 1'b0;
    check({tag, "_valid"}, {31'd0, mem_valid}, 32'd1);
    check({tag, "_data"}, mem_out, exp);
  endtask

  task automatic host_access(input string tag, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [DW-1:0] exp);
    host_req   = 1'b1;
    host_wr    = wr;
    host_addr  = a;
    host_wdata = d;
    #1;
    check({tag, "_gnt"}, {31'd0, host_gnt}, 32'd1);
    step();
    host_req = 1'b0;
    host_wr  = 1'b0;
    check({tag, "_rvalid"}, {31'd0, host_rvalid}, {31'd0, ~wr});
    if (!wr) check({tag, "_data"}, mem_out, exp);
  endtask

`ifdef CONV_MEM_INIT_CLEAR_EN
  // Counts edges from reset release until ready; INIT must ignore requests.
  task automatic wait_ready(input string tag);
    int cyc;
    cyc       = 0;
    mem_rd    = 1'b1;
    mem_index = 9'd3;
    host_req  = 1'b1;
    host_wr   = 1'b0;
    host_addr = 9'd4;
    #1;
    check({tag, "_init_gnt"}, {31'd0, host_gnt}, 32'd0);
    step();
    cyc++;
    mem_rd   = 1'b0;
    host_req = 1'b0;
    check({tag, "_init_valid"}, {30'd0, mem_valid, host_rvalid}, 32'd0);
    while (ready !== 1'b1 && cyc < 1000) begin
      step();
      cyc++;
    end
    check({tag, "_ready_cycles"}, cyc, 32'd512);
  endtask
`endif

  initial begin
    rst        = 1'b0;
    mem_index  = '0;
    mem_in     = '0;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    host_req   = 1'b0;
    host_wr    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_out", mem_out, 32'd0);
    check("rst_valids", {30'd0, mem_valid, host_rvalid}, 32'd0);
`ifdef CONV_MEM_INIT_CLEAR_EN
    check("rst_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    wait_ready("boot");
    host_access("h300", 1'b0, 9'd300, '0, 32'd0);
`else
    check("rst_ready", {31'd0, ready}, 32'd1);
    rst = 1'b1;
    #1;
    check("rel_ready", {31'd0, ready}, 32'd1);
    host_access("h300w", 1'b1, 9'd300, 32'h0000_0000, '0);
    host_access("h300", 1'b0, 9'd300, '0, 32'd0);
`endif

    // Write then read-after-write on the datapath; mem_out holds afterwards.
    dp_wr(9'd5, 32'hDEAD_BEEF);
    check("wr5_no_valid", {31'd0, mem_valid}, 32'd0);
    dp_rd("rd5", 9'd5, 32'hDEAD_BEEF);
    step();
    check("idle_valid", {31'd0, mem_valid}, 32'd0);
    check("idle_hold", mem_out, 32'hDEAD_BEEF);

    // Host write blocked by three datapath reads of the same word.
    dp_wr(9'd7, 32'h1111_1111);
    host_req   = 1'b1;
    host_wr    = 1'b1;
    host_addr  = 9'd7;
    host_wdata = 32'hA5A5_A5A5;
    mem_rd     = 1'b1;
    mem_index  = 9'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("blk_gnt", {31'd0, host_gnt}, 32'd0);
      step();
      check("blk_valid", {31'd0, mem_valid}, 32'd1);
      check("blk_data", mem_out, 32'h1111_1111);
    end
    mem_rd = 1'b0;
    #1;
    check("blk_gnt4", {31'd0, host_gnt}, 32'd1);
    step();
    host_req = 1'b0;
    host_wr  = 1'b0;
    check("blk_after", {30'd0, mem_valid, host_rvalid}, 32'd0);
    dp_rd("rd7", 9'd7, 32'hA5A5_A5A5);
    host_access("h7", 1'b0, 9'd7, '0, 32'hA5A5_A5A5);
    check("h7_no_dpvalid", {31'd0, mem_valid}, 32'd0);

    // Simultaneous write and read: write only, output held.
    mem_index = 9'd9;
    mem_in    = 32'h1234_5678;
    mem_wr    = 1'b1;
    mem_rd    = 1'b1;
    step();
    mem_wr = 1'b0;
    mem_rd = 1'b0;
    check("wr_rd_no_valid", {31'd0, mem_valid}, 32'd0);
    check("wr_rd_hold", mem_out, 32'hA5A5_A5A5);
    dp_rd("rd9", 9'd9, 32'h1234_5678);

    // Top and bottom words back to back.
    dp_wr(9'd511, 32'hCAFE_F00D);
    dp_wr(9'd0, 32'h0BAD_C0DE);
    mem_rd    = 1'b1;
    mem_index = 9'd0;
    step();
    check("b2b0_valid", {31'd0, mem_valid}, 32'd1);
    check("b2b0_data", mem_out, 32'h0BAD_C0DE);
    mem_index = 9'd511;
    step();
    mem_rd = 1'b0;
    check("b2b511_valid", {31'd0, mem_valid}, 32'd1);
    check("b2b511_data", mem_out, 32'hCAFE_F00D);
    step();
    check("b2b_end_valid", {31'd0, mem_valid}, 32'd0);

    // Reset in service clears outputs.
    rst = 1'b0;
    #1;
    check("rst2_mem_out", mem_out, 32'd0);
    check("rst2_valids", {30'd0, mem_valid, host_rvalid}, 32'd0);
    step();
    rst = 1'b1;
`ifdef CONV_MEM_INIT_CLEAR_EN
    repeat (200) step();
    check("mid_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst3_ready", {31'd0, ready}, 32'd0);
    check("rst3_mem_out", mem_out, 32'd0);
    step();
    rst = 1'b1;
    wait_ready("resweep");
    dp_rd("clr9", 9'd9, 32'd0);
    dp_rd("clr511", 9'd511, 32'd0);
`else
    #1;
    check("rst2_ready", {31'd0, ready}, 32'd1);
    dp_rd("keep9", 9'd9, 32'h1234_5678);
    dp_rd("keep511", 9'd511, 32'hCAFE_F00D);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
